// File: rtl/rst_seq_pkg.sv
// Shared types and limits for the staged reset sequencer.
package rst_seq_pkg;

    localparam int NUM_STAGES_MIN = 2;
    localparam int NUM_STAGES_MAX = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable up-counter that parks at its terminal count until reloaded.
module rst_seq_timer
    import rst_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             hold_i,
    input  logic [WIDTH-1:0] term_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == term_i);

    // Stopping at the terminal count is what keeps the counter from wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (!hold_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: all domains held, then freed one by one, bit 0 first.
// Define RSTSEQ_ACK_EN to gate each release (and DONE) on the previous domain's ack_i.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic [NUM_STAGES-1:0] ack_i,
    output logic [NUM_STAGES-1:0] stage_rst_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = $clog2(NUM_STAGES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);
    localparam logic [TMR_W-1:0] HOLD_TERM = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_TERM  = TMR_W'(GAP_CYCLES - 1);

    if (NUM_STAGES < NUM_STAGES_MIN || NUM_STAGES > NUM_STAGES_MAX) begin : g_bad_num_stages
        $error("reset_sequencer: NUM_STAGES out of range");
    end

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
    logic [IDX_W-1:0]      idx_nxt;
    logic [TMR_W-1:0]      tmr_term;
    logic                  tmr_load, tmr_hold, tmr_tc;
    logic                  ack_cur, ack_last;

`ifdef RSTSEQ_ACK_EN
    assign ack_cur  = ack_i[idx_q];
    assign ack_last = ack_i[NUM_STAGES-1];
`else
    logic unused_ack;
    assign unused_ack = ^ack_i;
    assign ack_cur    = 1'b1;
    assign ack_last   = 1'b1;
`endif

    assign idx_nxt  = idx_q + 1'b1;
    assign tmr_term = (state_q == HOLD) ? HOLD_TERM : GAP_TERM;

    rst_seq_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i ('0),
        .hold_i     (tmr_hold),
        .term_i     (tmr_term),
        .tc_o       (tmr_tc)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        stage_rst_d = stage_rst_q;
        tmr_load    = 1'b0;
        tmr_hold    = 1'b1;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d     = HOLD;
                    idx_d       = '0;
                    stage_rst_d = '1;
                    tmr_load    = 1'b1;
                end
            end
            HOLD: begin
                tmr_hold = 1'b0;
                if (tmr_tc) begin
                    state_d        = RELEASE;
                    idx_d          = '0;
                    stage_rst_d[0] = 1'b0;
                    tmr_load       = 1'b1;
                end
            end
            RELEASE: begin
                tmr_hold = 1'b0;
                // Reaching idx == LAST here means only the final ack is outstanding.
                if (idx_q == LAST_IDX) begin
                    if (ack_last) begin
                        state_d = DONE;
                    end
                end else if (tmr_tc && ack_cur) begin
                    stage_rst_d[idx_nxt] = 1'b0;
                    idx_d                = idx_nxt;
                    tmr_load             = 1'b1;
                    if (idx_nxt == LAST_IDX && ack_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HOLD;
            idx_q       <= '0;
            stage_rst_q <= '1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            stage_rst_q <= stage_rst_d;
        end
    end

    assign stage_rst_o = stage_rst_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: default instance (4 stages, hold 8, gap 4) and a minimal one (2/1/1).
module tb_reset_sequencer;

    localparam int N1 = 4, H1 = 8, G1 = 4, T1 = H1 + (N1 - 1) * G1;
    localparam int N2 = 2, H2 = 1, G2 = 1, T2 = H2 + (N2 - 1) * G2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic [N1-1:0] ack1;
    logic [N2-1:0] ack2;
    logic [N1-1:0] stage1;
    logic [N2-1:0] stage2;
    logic          busy1, done1, busy2, done2;

    always #5 clk = ~clk;

`ifdef RSTSEQ_ACK_EN
    assign ack1 = '1;
    assign ack2 = '1;
`else
    assign ack1 = '0;
    assign ack2 = '0;
`endif

    reset_sequencer #(.NUM_STAGES(N1), .HOLD_CYCLES(H1), .GAP_CYCLES(G1)) u_dut1 (
        .clk(clk), .rst(rst), .req_i(req), .ack_i(ack1),
        .stage_rst_o(stage1), .busy_o(busy1), .done_o(done1)
    );

    reset_sequencer #(.NUM_STAGES(N2), .HOLD_CYCLES(H2), .GAP_CYCLES(G2)) u_dut2 (
        .clk(clk), .rst(rst), .req_i(req), .ack_i(ack2),
        .stage_rst_o(stage2), .busy_o(busy2), .done_o(done2)
    );

    typedef struct {
        logic [7:0] stage;
        logic       busy;
        logic       done;
        int         cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   n1    = -1;
    int   n2    = -1;

    // n = edges since rst/accepted req was sampled; n > t means idle, -1 means never started.
    function automatic int next_n(int n, int t, logic r, logic q);
        if (r) return 0;
        if (n < 0) return -1;
        if (n > t) return q ? 0 : n;
        return n + 1;
    endfunction

    function automatic exp_t make_exp(int n, int h, int g, int nst, int t, int c);
        exp_t e;
        e.stage = '0;
        for (int k = 0; k < nst; k++) e.stage[k] = (n < h + k * g);
        e.busy = (n <= t);
        e.done = (n == t);
        e.cyc  = c;
        return e;
    endfunction

    task automatic tick(input logic r, input logic q);
        @(negedge clk);
        rst = r;
        req = q;
        cyc++;
        n1 = next_n(n1, T1, r, q);
        n2 = next_n(n2, T2, r, q);
        if (n1 >= 0) q1.push_back(make_exp(n1, H1, G1, N1, T1, cyc));
        if (n2 >= 0) q2.push_back(make_exp(n2, H2, G2, N2, T2, cyc));
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q1.size() != 0) begin
            e = q1.pop_front();
            n_vec++;
            if ({busy1, done1, stage1} !== {e.busy, e.done, e.stage[N1-1:0]}) begin
                n_bad++;
                $display("FAIL dut1 cyc %0d: got stage=%b busy=%b done=%b, want stage=%b busy=%b done=%b",
                         e.cyc, stage1, busy1, done1, e.stage[N1-1:0], e.busy, e.done);
            end
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q2.size() != 0) begin
            e = q2.pop_front();
            n_vec++;
            if ({busy2, done2, stage2} !== {e.busy, e.done, e.stage[N2-1:0]}) begin
                n_bad++;
                $display("FAIL dut2 cyc %0d: got stage=%b busy=%b done=%b, want stage=%b busy=%b done=%b",
                         e.cyc, stage2, busy2, done2, e.stage[N2-1:0], e.busy, e.done);
            end
        end
    end

    initial begin
        // Power-up: rst for 3 cycles, then the full sequence and a few idle cycles.
        repeat (3) tick(1'b1, 1'b0);
        repeat (24) tick(1'b0, 1'b0);

        // rst wins over a simultaneous req.
        tick(1'b1, 1'b1);
        repeat (22) tick(1'b0, 1'b0);

        // Single-cycle req from IDLE.
        tick(1'b0, 1'b1);
        repeat (23) tick(1'b0, 1'b0);

        // req held through RELEASE/DONE: ignored while busy, restarts once IDLE.
        tick(1'b0, 1'b1);
        repeat (12) tick(1'b0, 1'b0);
        repeat (12) tick(1'b0, 1'b1);
        repeat (24) tick(1'b0, 1'b0);

        // rst at edge 14 of a running sequence.
        tick(1'b1, 1'b0);
        repeat (13) tick(1'b0, 1'b0);
        repeat (2) tick(1'b1, 1'b0);
        repeat (24) tick(1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #2;
        if (q1.size() != 0 || q2.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d/%0d entries left, want 0/0", q1.size(), q2.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4: number of reset domains; legal range 2..8.
REQ-002 Parameter HOLD_CYCLES, default 8: cycles all domains are held in reset; legal minimum 1.
REQ-003 Parameter GAP_CYCLES, default 4: cycles between successive stage releases; legal minimum 1.
REQ-004 clk  input  1  single rising-edge clock; all state SHALL be clocked by clk only.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req_i  input  1  software reset request, sampled each edge.
REQ-007 ack_i  input  NUM_STAGES  per-domain "out of reset" acknowledge; see REQ-022.
REQ-008 stage_rst_o  output  NUM_STAGES  active-high synchronous reset per domain; bit 0 is released first.
REQ-009 busy_o  output  1  high whenever the state is not IDLE.
REQ-010 done_o  output  1  one-cycle pulse when the sequence completes.

Function
REQ-011 FSM states SHALL be IDLE, HOLD, RELEASE and DONE, with a stage index idx (0..NUM_STAGES-1) and a timer.
REQ-012 Edge numbering: edge n is the n-th rising edge of clk after rst or req_i is sampled.
REQ-013 HOLD: stage_rst_o SHALL be all ones; the timer counts edges; at edge HOLD_CYCLES the FSM SHALL go to RELEASE with idx=0, and stage_rst_o[0] SHALL clear at that edge.
REQ-014 RELEASE: stage_rst_o[k] SHALL clear at edge HOLD_CYCLES + k*GAP_CYCLES, for k = 1..NUM_STAGES-1.
REQ-015 The edge that clears stage_rst_o[NUM_STAGES-1] SHALL also move the FSM to DONE.
REQ-016 DONE SHALL last exactly one cycle with done_o=1, then go to IDLE. done_o SHALL be the registered state decode, with no combinational path from the inputs.
REQ-017 Released bits SHALL stay cleared (monotonic) until rst or an accepted req_i.
REQ-018 req_i=1 in IDLE SHALL, at the next edge: set stage_rst_o to all ones, clear the timer, and enter HOLD.
REQ-019 req_i while busy_o=1 (HOLD, RELEASE or DONE) SHALL be ignored; it is neither queued nor restarts the sequence.
REQ-020 The timer SHALL be $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1) bits wide and SHALL never wrap during a sequence.

Reset
REQ-021 While rst=1 the block SHALL set at each edge: state=HOLD, timer=0, idx=0, stage_rst_o=all ones, busy_o=1, done_o=0. rst takes priority over req_i and over any in-flight sequence; after rst deasserts, the full sequence SHALL run from edge 1.

Configuration
REQ-022 With macro RSTSEQ_ACK_EN defined, release of stage k+1 SHALL additionally wait for ack_i[k]=1.
- The timer holds at its terminal count while waiting.
- Release occurs at the first edge where both the gap has elapsed and ack_i[k]=1.
- DONE SHALL additionally wait for ack_i[NUM_STAGES-1]=1.
REQ-023 Without RSTSEQ_ACK_EN, ack_i SHALL remain a port but be ignored; timing SHALL be exactly as in REQ-013..REQ-016.

Structure
REQ-024 Package rst_seq_pkg SHALL hold the FSM state typedef (IDLE, HOLD, RELEASE, DONE) and the NUM_STAGES legal-range constants.
REQ-025 One sub-module, rst_seq_timer, SHALL provide the loadable up-counter with a terminal-count flag and a hold input; it is instantiated once.

Verification
REQ-026 Defaults, rst high for 3 cycles then low -> stage_rst_o bits clear at edges 8, 12, 16, 20; done_o high for exactly the cycle after edge 20; busy_o low after edge 21.
REQ-027 From IDLE, a 1-cycle req_i pulse -> stage_rst_o=4'b1111 after the next edge, then the same timing as REQ-026.
REQ-028 req_i held high during RELEASE and DONE -> no restart; done_o pulses once; IDLE is reached, and a new sequence starts only if req_i is still high in IDLE.
REQ-029 rst asserted at edge 14 (stage0 cleared, stage1 cleared) -> stage_rst_o=4'b1111 at the next edge; full timing restarts from edge 1 after deassert.
REQ-030 RSTSEQ_ACK_EN defined, ack_i[1] held low until edge 30 -> stage2 clears at edge 30 (not 16); stage3 clears at edge 34 if ack_i[2]=1.
REQ-031 HOLD_CYCLES=1, GAP_CYCLES=1, NUM_STAGES=2 -> stage0 clears at edge 1, stage1 clears at edge 2, done_o high in the following cycle.
